sys_rst_ctrl: RTL

SYS_RST_CTRL -- requirements
Module: sys_rst_ctrl

---
 rtl/sys_rst_ctrl.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/sys_rst_ctrl.sv
// sys_rst_ctrl -- system reset sequencer with watchdog and upgrade-button debouncer.
//
// Sequences the system reset after the asynchronous rstb_in is released: a
// 2-flop synchronizer, then a POR_CYCLES-long hold, then RUN. In RUN an optional
// watchdog can pull the system back through a one-cycle WDT_RST and a fresh
// POR hold. The raw upgrade button is synchronized and debounced.
//
// Ports:
//   clk               in   system clock
//   rstb_in           in   asynchronous active-low reset
//   sw_uart_upgrade_b in   raw active-low upgrade button (asynchronous)
//   during_sw_upgrade in   UART RAM upgrade in progress (holds core in reset)
//   wdt_en            in   watchdog enable level
//   wdt_kick          in   single-cycle watchdog restart pulse
//   wdt_timeout       in   watchdog timeout in cycles (0 disables)
//   rstb              out  system reset, active-low, registered
//   core_rstb         out  core reset, active-low, one cycle behind rstb
//   upgrade_req       out  debounced upgrade request, active-high
//   wdt_fired         out  sticky: watchdog caused the last reset
module sys_rst_ctrl #(
  parameter int unsigned POR_CYCLES = 16,
  parameter int unsigned DEB_CYCLES = 50000,
  parameter int unsigned WDT_WIDTH  = 24
) (
  input  logic                 clk,
  input  logic                 rstb_in,
  input  logic                 sw_uart_upgrade_b,
  input  logic                 during_sw_upgrade,
  input  logic                 wdt_en,
  input  logic                 wdt_kick,
  input  logic [WDT_WIDTH-1:0] wdt_timeout,
  output logic                 rstb,
  output logic                 core_rstb,
  output logic                 upgrade_req,
  output logic                 wdt_fired
);

  localparam int unsigned POR_W = $clog2(POR_CYCLES + 1);
  localparam int unsigned DEB_W = $clog2(DEB_CYCLES + 1);
  localparam logic [POR_W-1:0] POR_LAST = POR_W'(POR_CYCLES - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    SYNC     = 2'd0,
    POR_HOLD = 2'd1,
    RUN      = 2'd2,
    WDT_RST  = 2'd3
  } state_t;

  state_t               state, state_next;
  logic [1:0]           rst_sync;
  logic [1:0]           btn_sync;
  logic [POR_W-1:0]     por_cnt, por_cnt_next;
  logic [WDT_WIDTH-1:0] wdt_cnt, wdt_cnt_next;
  logic [WDT_WIDTH-1:0] wdt_last;
  logic                 wdt_active;
  logic                 wdt_fire;
  logic                 rstb_next;
  logic [DEB_W-1:0]     deb_cnt;
  logic                 stable;

  // Reset release synchronizer; assertion stays asynchronous.
  always_ff @(posedge clk or negedge rstb_in) begin
    if (!rstb_in) rst_sync <= '0;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end

  // Button synchronizer; idles high (button released).
  always_ff @(posedge clk or negedge rstb_in) begin
    if (!rstb_in) btn_sync <= '1;
    else          btn_sync <= {btn_sync[0], sw_uart_upgrade_b};
  end

  assign wdt_last   = wdt_timeout - WDT_WIDTH'(1);
  assign wdt_active = wdt_en && (wdt_timeout != '0) && !during_sw_upgrade;

  always_comb begin
    state_next   = state;
    por_cnt_next = por_cnt;
    wdt_cnt_next = '0;
    wdt_fire     = 1'b0;
    case (state)
      SYNC: begin
        por_cnt_next = '0;
        if (rst_sync[1]) state_next = POR_HOLD;
      end
      POR_HOLD: begin
        if (por_cnt == POR_LAST) begin
          state_next   = RUN;
          por_cnt_next = '0;
        end else begin
          por_cnt_next = por_cnt + POR_W'(1);
        end
      end
      RUN: begin
        if (wdt_active) begin
          // A kick on the match cycle takes priority over the timeout.
          if (wdt_kick) begin
            wdt_cnt_next = '0;
          end else if (wdt_cnt == wdt_last) begin
            wdt_fire   = 1'b1;
            state_next = WDT_RST;
          end else if (wdt_cnt != '1) begin
            wdt_cnt_next = wdt_cnt + WDT_WIDTH'(1);
          end else begin
            wdt_cnt_next = wdt_cnt;
          end
        end
      end
      WDT_RST: begin
        por_cnt_next = '0;
        state_next   = POR_HOLD;
      end
      default: state_next = SYNC;
    endcase
  end

  assign rstb_next = (state_next == RUN);

  // core_rstb is taken from the registered rstb, so it always trails rstb by
  // one cycle on both edges and also trails during_sw_upgrade by one cycle.
  always_ff @(posedge clk or negedge rstb_in) begin
    if (!rstb_in) begin
      state     <= SYNC;
      por_cnt   <= '0;
      wdt_cnt   <= '0;
      rstb      <= 1'b0;
      core_rstb <= 1'b0;
      wdt_fired <= 1'b0;
    end else begin
      state     <= state_next;
      por_cnt   <= por_cnt_next;
      wdt_cnt   <= wdt_cnt_next;
      rstb      <= rstb_next;
      core_rstb <= rstb & ~during_sw_upgrade;
      if (wdt_fire) wdt_fired <= 1'b1;
    end
  end

  // Debouncer: the stable level changes only after DEB_CYCLES consecutive
  // cycles of disagreement; frozen while the sequencer sits in SYNC.
  always_ff @(posedge clk or negedge rstb_in) begin
    if (!rstb_in) begin
      deb_cnt     <= '0;
      stable      <= 1'b1;
      upgrade_req <= 1'b0;
    end else begin
      upgrade_req <= ~stable;
      if (state == SYNC) begin
        deb_cnt <= '0;
      end else if (btn_sync[1] != stable) begin
        if (deb_cnt == DEB_LAST) begin
          stable  <= btn_sync[1];
          deb_cnt <= '0;
        end else begin
          deb_cnt <= deb_cnt + DEB_W'(1);
        end
      end else begin
        deb_cnt <= '0;
      end
    end
  end

endmodule
